// File: rtl/bit_pattern_scan_sched.sv
// Round-robin scheduler sharing one serial 4-bit overlapping pattern detector
// among four requesters; reports a per-frame match count tagged with the requester ID.
module bit_pattern_scan_sched #(
  parameter int         FRAME_W = 8,
  parameter logic [3:0] PATTERN = 4'b1010,
  parameter int         CNT_W   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             req,
  input  logic [4*FRAME_W-1:0]   req_data,
  output logic [3:0]             grant,
  output logic                   busy,
  output logic                   z,
  output logic                   done,
  output logic [1:0]             done_id,
  output logic [CNT_W-1:0]       match_count
);

  localparam int BC_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(FRAME_W - 1);
  localparam logic [BC_W-1:0] FIRST_MATCH = BC_W'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           sel_q, sel_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [2:0]           hist_q, hist_d;
  logic [BC_W-1:0]      bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 z_q, z_d;
  logic                 done_q, done_d;
  logic [1:0]           done_id_q, done_id_d;
  logic [CNT_W-1:0]     match_count_q, match_count_d;

  logic [1:0]           winner;
  logic [3:0]           window;

  // Walk offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin : arbiter
    logic [1:0] idx;
    winner = ptr_q;
    idx    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) winner = idx;
    end
  end

  assign window = {hist_q, shreg_q[FRAME_W-1]};

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    shreg_d       = shreg_q;
    hist_d        = hist_q;
    bitcnt_d      = bitcnt_q;
    cnt_d         = cnt_q;
    grant_d       = 4'b0000;
    busy_d        = 1'b0;
    z_d           = 1'b0;
    done_d        = 1'b0;
    done_id_d     = done_id_q;
    match_count_d = match_count_q;

    unique case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d  = SCAN;
          grant_d  = 4'b0001 << winner;
          sel_d    = winner;
          shreg_d  = req_data[int'(winner)*FRAME_W +: FRAME_W];
          hist_d   = 3'b000;
          bitcnt_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end
      end

      SCAN: begin
        busy_d   = 1'b1;
        shreg_d  = shreg_q << 1;
        hist_d   = window[2:0];
        bitcnt_d = bitcnt_q + BC_W'(1);
        // A window is only complete once three earlier bits of this frame are in hist.
        if (bitcnt_q >= FIRST_MATCH && window == PATTERN) begin
          z_d   = 1'b1;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (bitcnt_q == LAST_BIT) state_d = REPORT;
      end

      REPORT: begin
        done_d        = 1'b1;
        done_id_d     = sel_q;
        match_count_d = cnt_q;
        ptr_d         = sel_q + 2'd1;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      sel_q         <= 2'd0;
      shreg_q       <= '0;
      hist_q        <= 3'b000;
      bitcnt_q      <= '0;
      cnt_q         <= '0;
      grant_q       <= 4'b0000;
      busy_q        <= 1'b0;
      z_q           <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= 2'd0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      shreg_q       <= shreg_d;
      hist_q        <= hist_d;
      bitcnt_q      <= bitcnt_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      z_q           <= z_d;
      done_q        <= done_d;
      done_id_q     <= done_id_d;
      match_count_q <= match_count_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign z           = z_q;
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_bit_pattern_scan_sched.sv
// Scoreboard bench: a transaction-level model predicts grant/z/busy/done per cycle,
// a separate negedge monitor compares the DUT against those predictions.
module tb_bit_pattern_scan_sched;

  localparam int         FW  = 8;
  localparam logic [3:0] PAT = 4'b1010;
  localparam int         CW  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        req = 4'b0000;
  logic [4*FW-1:0]   req_data = '0;
  logic [3:0]        grant;
  logic              busy, z, done;
  logic [1:0]        done_id;
  logic [CW-1:0]     match_count;

  logic [3:0]        req_s = 4'b0000;
  logic [4*FW-1:0]   req_data_s = '0;
  logic [3:0]        grant_s;
  logic              busy_s, z_s, done_s;
  logic [1:0]        done_id_s;
  logic [1:0]        match_count_s;

  always #5 clock = ~clock;

  bit_pattern_scan_sched #(.FRAME_W(FW), .PATTERN(PAT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .busy(busy), .z(z), .done(done),
    .done_id(done_id), .match_count(match_count)
  );

  bit_pattern_scan_sched #(.FRAME_W(FW), .PATTERN(4'b1111), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .req(req_s), .req_data(req_data_s),
    .grant(grant_s), .busy(busy_s), .z(z_s), .done(done_s),
    .done_id(done_id_s), .match_count(match_count_s)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count overlapping windows of a frame read MSB-first, saturating.
  function automatic int count_matches(input logic [FW-1:0] f, input logic [3:0] pat, input int cw);
    int n = 0;
    int mx = (1 << cw) - 1;
    for (int k = 3; k < FW; k++)
      if (f[FW+2-k -: 4] == pat) n++;
    return (n > mx) ? mx : n;
  endfunction

  typedef struct {
    int cyc;
    int id;
    int cnt;
  } txn_t;

  txn_t grant_q[$];
  txn_t done_q[$];
  bit   exp_z[int];
  bit   exp_busy[int];
  bit   rst_chk[int];
  int   cyc = 0;
  int   idle_from = 0;
  int   ptr_m = 0;

  // Model: decides at each edge what the DUT must show in later cycles.
  always @(posedge clock) begin : model
    int c;
    int w;
    logic [FW-1:0] f;
    c = cyc;
    if (reset) begin
      ptr_m = 0;
      idle_from = c + 1;
      while (grant_q.size() > 0 && grant_q[$].cyc > c) void'(grant_q.pop_back());
      while (done_q.size() > 0 && done_q[$].cyc > c) void'(done_q.pop_back());
      for (int i = c + 1; i <= c + FW + 4; i++) begin
        exp_z.delete(i);
        exp_busy.delete(i);
      end
      rst_chk[c+1] = 1'b1;
    end else if (c >= idle_from && req != 4'b0000) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && req[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
      f = req_data[w*FW +: FW];
      grant_q.push_back('{cyc: c + 1, id: w, cnt: 0});
      for (int i = c + 1; i <= c + FW + 1; i++) exp_busy[i] = 1'b1;
      for (int k = 3; k < FW; k++)
        if (f[FW+2-k -: 4] == PAT) exp_z[c + 2 + k] = 1'b1;
      done_q.push_back('{cyc: c + FW + 2, id: w, cnt: count_matches(f, PAT, CW)});
      ptr_m = (w + 1) % 4;
      idle_from = c + FW + 2;
    end
    cyc = c + 1;
  end

  int held_id  = 0;
  int held_cnt = 0;

  always @(negedge clock) begin : monitor
    txn_t t;
    if (cyc > 0) begin
      if (rst_chk.exists(cyc)) begin
        rst_chk.delete(cyc);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_z", z, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_match_count", match_count, 0);
        held_id  = 0;
        held_cnt = 0;
      end else begin
        if (grant_q.size() > 0 && grant_q[0].cyc == cyc) begin
          t = grant_q.pop_front();
          check("grant", grant, 32'(4'b0001 << t.id));
        end else begin
          check("grant_quiet", grant, 0);
        end
        check("z", z, exp_z.exists(cyc) ? 1 : 0);
        exp_z.delete(cyc);
        check("busy", busy, exp_busy.exists(cyc) ? 1 : 0);
        exp_busy.delete(cyc);
        if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
          t = done_q.pop_front();
          check("done", done, 1);
          held_id  = t.id;
          held_cnt = t.cnt;
        end else begin
          check("done_quiet", done, 0);
        end
        check("done_id", done_id, held_id);
        check("match_count", match_count, held_cnt);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input int id, input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      step();
      if (grant[id]) seen = 1'b1;
    end
  endtask

  task automatic serve(input int id, input logic [FW-1:0] frame);
    bit seen;
    req_data[id*FW +: FW] = frame;
    req[id] = 1'b1;
    wait_grant(id, 30, seen);
    req[id] = 1'b0;
    check("serve_grant_seen", 32'(seen), 1);
    repeat (FW + 2) step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit        seen;
    int        gid[5];
    int        gcyc[5];
    int        ng;
    int        nz;
    int        exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    step();

    // Round robin with all four requesting and ptr at 0.
    req_data = {8'hFF, 8'h0A, 8'h00, 8'hAA};
    req = 4'b1111;
    ng = 0;
    for (int n = 0; n < 80 && ng < 5; n++) begin
      step();
      if (grant != 4'b0000) begin
        gid[ng]  = (grant == 4'b0001) ? 0 : (grant == 4'b0010) ? 1 : (grant == 4'b0100) ? 2 : 3;
        gcyc[ng] = n;
        ng++;
      end
    end
    req = 4'b0000;
    check("rr_grants_seen", ng, 5);
    for (int i = 0; i < ng; i++) begin
      check("rr_order", gid[i], exp_order[i]);
      if (i > 0) check("rr_spacing", gcyc[i] - gcyc[i-1], FW + 2);
    end
    repeat (FW + 2) step();

    // Single requests, then the cross-frame history case.
    serve(0, 8'b10101010);
    serve(2, 8'b01010000);
    serve(1, 8'b00000101);
    serve(1, 8'b00000000);

    // Reset four cycles into SCAN; afterwards ptr restarts at 0.
    req_data[3*FW +: FW] = 8'hAA;
    req_data[0*FW +: FW] = 8'h5A;
    req = 4'b1000;
    wait_grant(3, 30, seen);
    check("pre_reset_grant", 32'(seen), 1);
    repeat (3) step();
    reset = 1'b1;
    req = 4'b1001;
    step();
    reset = 1'b0;
    wait_grant(0, 30, seen);
    check("post_reset_first_grant", 32'(seen), 1);
    req[0] = 1'b0;
    wait_grant(3, 30, seen);
    check("post_reset_second_grant", 32'(seen), 1);
    req[3] = 1'b0;
    repeat (FW + 2) step();

    // Randomised traffic with drops, holds and occasional reset.
    for (int n = 0; n < 1500; n++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && grant[i]) begin
          if ($urandom_range(0, 3) == 0) req_data[i*FW +: FW] = 8'($urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req_data[i*FW +: FW] = ($urandom_range(0, 2) == 0) ? (8'hAA ^ 8'($urandom_range(0, 15)))
                                                                : 8'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    reset = 1'b0;
    req = 4'b0000;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      if (done_q.size() == 0 && grant_q.size() == 0) seen = 1'b1;
    end
    check("drain_scoreboard", 32'(seen), 1);
    repeat (2) step();

    // Saturating counter instance: 8'hFF against 1111 with a 2-bit count.
    req_data_s = {24'h0, 8'hFF};
    req_s = 4'b0001;
    nz = 0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      if (grant_s[0]) req_s = 4'b0000;
      if (z_s) nz++;
      if (done_s) seen = 1'b1;
    end
    check("sat_done_seen", 32'(seen), 1);
    check("sat_z_pulses", nz, 5);
    check("sat_match_count", match_count_s, 32'(count_matches(8'hFF, 4'b1111, 2)));
    check("sat_done_id", done_id_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
